// File: rtl/lcd_bus_writer.sv
// HD44780-style LCD bus write sequencer: one byte (or nibble) per handshake,
// driving RS/DB with programmable setup, EN-high and EN-low phases.
module lcd_bus_writer #(
    parameter bit BUS4    = 1'b0,
    parameter int T_SETUP = 3,
    parameter int T_EN_HI = 27778,
    parameter int T_EN_LO = 27778,
    parameter int CNT_W   = 16,
    localparam int DB_W   = BUS4 ? 4 : 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_rs,
    input  logic [7:0]      req_data,
    input  logic            req_single,
    output logic            lcd_rs,
    output logic            lcd_en,
    output logic [DB_W-1:0] lcd_db,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_EN_HI = 3'd2,
        ST_EN_LO = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] EN_HI_LAST = CNT_W'(T_EN_HI - 1);
    localparam logic [CNT_W-1:0] EN_LO_LAST = CNT_W'(T_EN_LO - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lcd_rs_q, lcd_rs_d;
    logic [DB_W-1:0]   lcd_db_q, lcd_db_d;
    logic              lcd_en_q;
    logic              done_q;
    logic              busy_q;
    logic              pend_q, pend_d;
    logic [3:0]        lo_nib_q, lo_nib_d;
    logic [DB_W-1:0]   db_first;
    logic [DB_W-1:0]   db_second;

    // What goes on the bus at accept time and at the second-nibble SETUP entry.
    generate
        if (BUS4) begin : g_bus4
            assign db_first  = req_data[7:4];
            assign db_second = lo_nib_q;
        end else begin : g_bus8
            assign db_first  = req_data;
            assign db_second = {lcd_db_q[7:4], lo_nib_q};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        lcd_rs_d = lcd_rs_q;
        lcd_db_d = lcd_db_q;
        pend_d   = pend_q;
        lo_nib_d = lo_nib_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    state_d  = ST_SETUP;
                    lcd_rs_d = req_rs;
                    lcd_db_d = db_first;
                    lo_nib_d = req_data[3:0];
                    pend_d   = BUS4 && !req_single;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_EN_HI;
                    cnt_d   = '0;
                end
            end
            ST_EN_HI: begin
                if (cnt_q == EN_HI_LAST) begin
                    state_d = ST_EN_LO;
                    cnt_d   = '0;
                end
            end
            ST_EN_LO: begin
                if (cnt_q == EN_LO_LAST) begin
                    cnt_d = '0;
                    if (pend_q) begin
                        pend_d   = 1'b0;
                        lcd_db_d = db_second;
                        state_d  = ST_SETUP;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            lcd_rs_q <= 1'b0;
            lcd_db_q <= '0;
            lcd_en_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            pend_q   <= 1'b0;
            lo_nib_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lcd_rs_q <= lcd_rs_d;
            lcd_db_q <= lcd_db_d;
            lcd_en_q <= (state_d == ST_EN_HI);
            done_q   <= (state_d == ST_DONE);
            busy_q   <= (state_d != ST_IDLE);
            pend_q   <= pend_d;
            lo_nib_q <= lo_nib_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_en    = lcd_en_q;
    assign lcd_db    = lcd_db_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
